// File: rtl/final_soc_keycode_pkg.sv
// Shared constants for the final_soc keycode receive path: Avalon s1
// register addresses and the bit positions used inside those registers.
package final_soc_keycode_pkg;

  // Avalon s1 word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLR    = 2'd3;

  // DATA register: head-entry valid flag
  localparam int DATA_VALID_BIT   = 8;

  // STATUS register flags (count occupies the low bits)
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;

  // CTRL register fields
  localparam int CTRL_IRQ_EN_BIT  = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/final_soc_keycode_rx_keycode_fifo.sv
// Synchronous keycode FIFO. A pop on an empty FIFO is ignored, a push on a
// full FIFO is accepted only when a pop frees a slot in the same cycle, and
// flush discards any same-cycle push/pop. Storage is not reset.
module keycode_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DATA_W-1:0]        i_din,
  output logic [DATA_W-1:0]        o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_full;
  logic              w_empty;
  logic              w_do_pop;
  logic              w_do_push;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == {CNT_W{1'b0}});

  // A pop needs data; a push needs a free slot, which a same-cycle pop provides
  assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
  assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

  // Occupancy update: push and pop together leave the count unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  // Entry storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/final_soc_keycode_rx.sv
// Hardware-to-CPU keycode receiver on the final_soc Avalon bus. Keycodes from
// the hardware decoder are queued in a FIFO; the CPU pops them through the
// DATA register and gets a level interrupt while entries are pending.
module final_soc_keycode_rx
  import final_soc_keycode_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              w_rd;
  logic              w_wr;
  logic              w_pop;
  logic              w_flush;
  logic              w_ctrl_wr;
  logic              w_ovf_clr;
  logic              w_ovf_set;
  logic [DATA_W-1:0] w_dout;
  logic [CNT_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_rdata;
  logic              r_overflow;
  logic              r_irq_en;
  logic              w_unused;

  assign w_rd      = chipselect & ~read_n;
  assign w_wr      = chipselect & ~write_n;
  assign w_pop     = w_rd & (address == ADDR_DATA);
  assign w_ctrl_wr = w_wr & (address == ADDR_CTRL);
  assign w_flush   = w_ctrl_wr & writedata[CTRL_FLUSH_BIT];
  assign w_ovf_clr = w_wr & (address == ADDR_CLR);
  // A push is lost only when full with no freeing pop; a flush swallows it silently
  assign w_ovf_set = in_valid & w_full & ~w_pop & ~w_flush;

  // Only the CTRL field bits of writedata carry meaning
  assign w_unused  = ^writedata[31:2];

  keycode_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (in_valid),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (in_data),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow flag (set beats clear) and interrupt enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end else begin
        r_overflow <= r_overflow;
      end
      if (w_ctrl_wr) r_irq_en <= writedata[CTRL_IRQ_EN_BIT];
    end
  end

  // Zero-latency read mux; unused bits read as zero
  always_comb begin
    w_rdata = 32'h0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) begin
          w_rdata[DATA_W-1:0]     = w_dout;
          w_rdata[DATA_VALID_BIT] = 1'b1;
        end else begin
          w_rdata = 32'h0;
        end
      end
      ADDR_STATUS: begin
        w_rdata[CNT_W-1:0]        = w_count;
        w_rdata[STATUS_EMPTY_BIT] = w_empty;
        w_rdata[STATUS_FULL_BIT]  = w_full;
        w_rdata[STATUS_OVF_BIT]   = r_overflow;
      end
      ADDR_CTRL: begin
        w_rdata[CTRL_IRQ_EN_BIT]  = r_irq_en;
      end
      default: begin
        w_rdata = 32'h0;
      end
    endcase
  end

  assign readdata = w_rdata;
  assign irq      = r_irq_en & ~w_empty;
  assign in_ready = ~w_full;

endmodule

// File: tb/tb_final_soc_keycode_rx.sv
// Directed self-checking bench for final_soc_keycode_rx. Pushed keycodes go
// into a scoreboard queue; every DATA read pops and compares against it.
module tb_final_soc_keycode_rx;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;

  int          checks;
  int          errors;
  logic [7:0]  mq[$];
  logic        m_ovf;
  logic        m_irq_en;

  final_soc_keycode_rx #(.DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus/source cycle: drive at negedge, check mid-cycle, then advance the model
  task automatic step(input logic rd, input logic wr, input logic [1:0] a,
                      input logic [31:0] wd, input logic v, input logic [7:0] d,
                      input string tag);
    logic [31:0] exp;
    logic        fl;
    logic        pop_ok;
    @(negedge clk);
    address    = a;
    chipselect = rd | wr;
    read_n     = ~rd;
    write_n    = ~wr;
    writedata  = wd;
    in_valid   = v;
    in_data    = d;
    #2;
    check({tag, "_irq"}, {31'h0, irq}, {31'h0, (m_irq_en && mq.size() != 0)});
    check({tag, "_rdy"}, {31'h0, in_ready}, {31'h0, (mq.size() < 16)});
    if (rd) begin
      exp = 32'h0;
      case (a)
        2'd0: if (mq.size() != 0) exp = 32'h100 | {24'h0, mq[0]};
        2'd1: begin
          exp[4:0] = 5'(mq.size());
          exp[8]   = (mq.size() == 0);
          exp[9]   = (mq.size() == 16);
          exp[10]  = m_ovf;
        end
        2'd2: exp[0] = m_irq_en;
        default: exp = 32'h0;
      endcase
      check({tag, "_rd"}, readdata, exp);
    end
    fl     = wr && (a == 2'd2) && wd[1];
    pop_ok = rd && (a == 2'd0) && (mq.size() != 0);
    if (wr && a == 2'd3) m_ovf = 1'b0;
    if (fl) begin
      mq.delete();
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (v) begin
        if (mq.size() < 16) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    if (wr && a == 2'd2) m_irq_en = wd[0];
  endtask

  task automatic rd(input logic [1:0] a, input string tag);
    step(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h00, tag);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd, input string tag);
    step(1'b0, 1'b1, a, wd, 1'b0, 8'h00, tag);
  endtask

  task automatic push(input logic [7:0] d, input string tag);
    step(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, d, tag);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    m_ovf      = 1'b0;
    m_irq_en   = 1'b0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1: reset state
    #1;
    check("t1_irq", {31'h0, irq}, 32'h0);
    check("t1_rdy", {31'h0, in_ready}, 32'h1);
    rd(2'd1, "t1_status");
    check("t1_status_c", readdata, 32'h100);
    rd(2'd0, "t1_data");
    check("t1_data_c", readdata, 32'h000);

    // 2: two pushes, enable irq, pop both
    push(8'h1C, "t2_p0");
    push(8'h32, "t2_p1");
    wr(2'd2, 32'h1, "t2_en");
    rd(2'd0, "t2_d0");
    check("t2_d0_c", readdata, 32'h11C);
    check("t2_irq_hi", {31'h0, irq}, 32'h1);
    rd(2'd0, "t2_d1");
    check("t2_d1_c", readdata, 32'h132);
    rd(2'd1, "t2_st");
    check("t2_st_c", readdata, 32'h100);
    check("t2_irq_lo", {31'h0, irq}, 32'h0);

    // 3: overflow with 17 pushes
    for (int i = 1; i <= 17; i++) push(8'(i), "t3_push");
    rd(2'd1, "t3_st");
    check("t3_st_c", readdata, 32'h610);
    for (int i = 1; i <= 16; i++) begin
      rd(2'd0, "t3_pop");
      check("t3_pop_c", readdata, 32'h100 | 32'(i));
    end
    wr(2'd3, 32'h0, "t3_clr");
    rd(2'd1, "t3_st2");
    check("t3_ovf_c", {31'h0, readdata[10]}, 32'h0);

    // 4: simultaneous push and pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), "t4_fill");
    step(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 8'h55, "t4_pp");
    check("t4_pp_c", readdata, 32'h120);
    rd(2'd1, "t4_st");
    check("t4_st_c", readdata, 32'h210);
    for (int i = 0; i < 16; i++) rd(2'd0, "t4_pop");
    check("t4_last_c", readdata, 32'h155);

    // 5: flush with a same-cycle push
    push(8'hA1, "t5_p0");
    push(8'hA2, "t5_p1");
    push(8'hA3, "t5_p2");
    step(1'b0, 1'b1, 2'd2, 32'h3, 1'b1, 8'h77, "t5_fl");
    rd(2'd1, "t5_st");
    check("t5_st_c", readdata, 32'h100);
    rd(2'd2, "t5_ctrl");
    check("t5_ctrl_c", readdata, 32'h1);
    check("t5_irq_c", {31'h0, irq}, 32'h0);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i), "t6_push");
    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h45;
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_irq_rst", {31'h0, irq}, 32'h0);
    check("t6_rdy_rst", {31'h0, in_ready}, 32'h1);
    mq.delete();
    m_ovf    = 1'b0;
    m_irq_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    rd(2'd1, "t6_st");
    check("t6_st_c", readdata, 32'h100);
    check("t6_irq_c", {31'h0, irq}, 32'h0);
    rd(2'd2, "t6_ctrl");
    check("t6_ctrl_c", readdata, 32'h0);

    @(negedge clk);
    chipselect = 1'b0;
    read_n     = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
